// File: rtl/ram_pkg.sv
// ram_pkg: shared state enum, byte-lane count and parameter sanity check for single_port_ram_be
package ram_pkg;
  typedef enum logic {CLEAR, RUN} state_e;
  function automatic int num_bytes(input int dw);
    return dw / 8;
  endfunction
  function automatic bit cfg_ok(input int dw, input int oreg);
    return (dw % 8 == 0) && (oreg == 0 || oreg == 1);
  endfunction
endpackage

// File: rtl/single_port_ram_be_if.sv
// single_port_ram_be_if: access bus (req/write_en/addr/din/byte_en in; ready/dout/dout_valid/init_done out)
interface single_port_ram_be_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  localparam int NUM_BYTES = ram_pkg::num_bytes(DATA_WIDTH);
  logic                  req;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [NUM_BYTES-1:0]  byte_en;
  logic                  ready;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  init_done;
  modport master (output req, write_en, addr, din, byte_en, input ready, dout, dout_valid, init_done);
  modport slave  (input req, write_en, addr, din, byte_en, output ready, dout, dout_valid, init_done);
endinterface

// File: rtl/single_port_ram_be_core.sv
// single_port_ram_be_core: unreset byte-lane storage array with registered read (clk, rst, en_i, we_i, addr_i, wdata_i, be_i -> rdata_o)
module single_port_ram_be_core #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTES  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_BYTES-1:0]  be_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++)
      if (en_i && we_i && be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else if (en_i && !we_i) rdata_q <= mem[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/single_port_ram_be.sv
// single_port_ram_be: byte-enable RAM with post-reset clear sequencer and valid pipeline (clk, reset, bus_if slave)
module single_port_ram_be
  import ram_pkg::*;
#(
  parameter int                                ADDR_WIDTH     = 14,
  parameter int                                DATA_WIDTH     = 32,
  parameter int                                OUT_REG        = 0,
  parameter int                                CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0]             CLEAR_VALUE    = '0
) (
  input logic                 clk,
  input logic                 reset,
  single_port_ram_be_if.slave bus_if
);
  localparam int NB = num_bytes(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(2**ADDR_WIDTH - 1);
  if (!cfg_ok(DATA_WIDTH, OUT_REG)) begin : g_cfg
    $error("single_port_ram_be: DATA_WIDTH must be a multiple of 8 and OUT_REG 0 or 1");
  end
  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  ready_q, init_q, v1_q, v2_q;
  logic [DATA_WIDTH-1:0] rdata, dout_q;
  logic                  clr, acc, rd, mem_en, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_be;
  always_comb begin
    clr       = (CLEAR_ON_RESET != 0) && (state_q == CLEAR);
    acc       = bus_if.req && ready_q;
    rd        = acc && !bus_if.write_en;
    mem_en    = clr || acc;
    mem_we    = clr || bus_if.write_en;
    mem_addr  = clr ? cnt_q[ADDR_WIDTH-1:0] : bus_if.addr;
    mem_wdata = clr ? CLEAR_VALUE : bus_if.din;
    mem_be    = clr ? '1 : bus_if.byte_en;
    cnt_d     = clr ? cnt_q + 1'b1 : cnt_q;
    state_d   = (state_q == RUN || CLEAR_ON_RESET == 0 || cnt_q == LAST) ? RUN : CLEAR;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      init_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= state_d == RUN;
      init_q  <= state_d == RUN;
      v1_q    <= rd;
      v2_q    <= v1_q;
      dout_q  <= v1_q ? rdata : dout_q;
    end
  end
  single_port_ram_be_core #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_BYTES (NB)
  ) u_core (
    .clk    (clk),
    .rst    (reset),
    .en_i   (mem_en),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(mem_wdata),
    .be_i   (mem_be),
    .rdata_o(rdata)
  );
  assign bus_if.ready      = ready_q;
  assign bus_if.init_done  = init_q;
  assign bus_if.dout_valid = (OUT_REG != 0) ? v2_q : v1_q;
  assign bus_if.dout       = (OUT_REG != 0) ? dout_q : rdata;
endmodule

// File: tb/tb_single_port_ram_be.sv
// tb_single_port_ram_be: directed checks of clear, byte lanes, latency, ignored requests and mid-flight reset
module tb_single_port_ram_be;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam logic [31:0] CV = 32'hA5A5A5A5;
  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  single_port_ram_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
  single_port_ram_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();
  single_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV))
    u0 (.clk(clk), .reset(rst0), .bus_if(b0.slave));
  single_port_ram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV))
    u1 (.clk(clk), .reset(rst1), .bus_if(b1.slave));
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drv0(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    b0.req = r; b0.write_en = w; b0.addr = a; b0.din = d; b0.byte_en = be;
  endtask
  task automatic drv1(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    b1.req = r; b1.write_en = w; b1.addr = a; b1.din = d; b1.byte_en = be;
  endtask
  initial begin
    drv0(1'b1, 1'b1, 4'd0, 32'h1, 4'hF);
    drv1(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    @(negedge clk);
    chk1("rst_ready", b0.ready, 1'b0);
    chk1("rst_valid", b0.dout_valid, 1'b0);
    chk32("rst_dout", b0.dout, 32'h0);
    chk1("rst_init", b0.init_done, 1'b0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk1("clear_ready", b0.ready, 1'b0);
      chk1("clear_valid", b0.dout_valid, 1'b0);
      @(negedge clk);
    end
    chk1("clear_ready_up", b0.ready, 1'b1);
    chk1("clear_init_up", b0.init_done, 1'b1);
    b0.req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drv0(1'b1, 1'b0, 4'(i), 32'h0, 4'h0);
      @(negedge clk);
      chk1("clear_rd_valid", b0.dout_valid, 1'b1);
      chk32("clear_rd_data", b0.dout, CV);
    end
    b0.req = 1'b0;
    @(negedge clk);
    chk1("idle_valid", b0.dout_valid, 1'b0);
    drv0(1'b1, 1'b1, 4'd3, 32'h11223344, 4'hF);
    @(negedge clk);
    chk1("be_wr1_valid", b0.dout_valid, 1'b0);
    chk32("be_wr1_dout", b0.dout, CV);
    drv0(1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'b0101);
    @(negedge clk);
    chk1("be_wr2_valid", b0.dout_valid, 1'b0);
    drv0(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    @(negedge clk);
    chk1("be_rd_valid", b0.dout_valid, 1'b1);
    chk32("be_rd_data", b0.dout, 32'h11BB33DD);
    b0.req = 1'b0;
    @(negedge clk);
    chk1("be_one_pulse", b0.dout_valid, 1'b0);
    chk32("be_dout_hold", b0.dout, 32'h11BB33DD);
    drv0(1'b1, 1'b1, 4'd7, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk1("wtr_wr_valid", b0.dout_valid, 1'b0);
    chk32("wtr_wr_dout", b0.dout, 32'h11BB33DD);
    drv0(1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
    @(negedge clk);
    chk1("wtr_rd_valid", b0.dout_valid, 1'b1);
    chk32("wtr_rd_data", b0.dout, 32'hDEADBEEF);
    drv0(1'b1, 1'b1, 4'd7, 32'hFFFFFFFF, 4'h0);
    @(negedge clk);
    drv0(1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
    @(negedge clk);
    chk32("be0_noop", b0.dout, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      drv0(1'b1, 1'b1, 4'(i), 32'h1000 + 32'(i), 4'hF);
      drv1(1'b1, 1'b1, 4'(i), 32'h2000 + 32'(i), 4'hF);
      @(negedge clk);
    end
    chk1("lat0_pre", b0.dout_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drv0(1'b1, 1'b0, 4'(i), 32'h0, 4'h0);
      drv1(1'b1, 1'b0, 4'(i), 32'h0, 4'h0);
      @(negedge clk);
      chk1("lat0_valid", b0.dout_valid, 1'b1);
      chk32("lat0_data", b0.dout, 32'h1000 + 32'(i));
      if (i == 0) chk1("lat1_first", b1.dout_valid, 1'b0);
      else begin
        chk1("lat1_valid", b1.dout_valid, 1'b1);
        chk32("lat1_data", b1.dout, 32'h2000 + 32'(i - 1));
      end
    end
    b0.req = 1'b0;
    b1.req = 1'b0;
    @(negedge clk);
    chk1("lat0_end", b0.dout_valid, 1'b0);
    chk1("lat1_last_valid", b1.dout_valid, 1'b1);
    chk32("lat1_last_data", b1.dout, 32'h2002);
    @(negedge clk);
    chk1("lat1_end", b1.dout_valid, 1'b0);
    drv1(1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    rst1 = 1'b1;
    b1.req = 1'b0;
    #1;
    chk1("mid_valid", b1.dout_valid, 1'b0);
    chk32("mid_dout", b1.dout, 32'h0);
    chk1("mid_ready", b1.ready, 1'b0);
    chk1("mid_init", b1.init_done, 1'b0);
    @(negedge clk);
    rst1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk1("mid_clear_ready", b1.ready, 1'b0);
      chk1("mid_clear_valid", b1.dout_valid, 1'b0);
      @(negedge clk);
    end
    chk1("mid_ready_up", b1.ready, 1'b1);
    chk1("mid_init_up", b1.init_done, 1'b1);
    drv1(1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
    @(negedge clk);
    b1.req = 1'b0;
    chk1("mid_rd_wait", b1.dout_valid, 1'b0);
    @(negedge clk);
    chk1("mid_rd_valid", b1.dout_valid, 1'b1);
    chk32("mid_rd_data", b1.dout, CV);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/single_port_ram_be.md
# single_port_ram_be

Parametrised single-port synchronous RAM for the MCU data/code memory path. It generalises the fixed 8-bit RAM to any multiple-of-8 data width, with per-byte write enables and an optional output pipeline register. A built-in clear sequencer zero-fills (or pattern-fills) the array after reset. A req/ready handshake with a dout_valid strobe lets the core and the debug/loader port know exactly when data is usable.

## Interface
- ADDR_WIDTH, 14, address bits; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width; must be a multiple of 8; NUM_BYTES = DATA_WIDTH/8
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
- CLEAR_ON_RESET, 1, 1 = fill the array with CLEAR_VALUE after reset; 0 = skip the fill
- CLEAR_VALUE, 0, DATA_WIDTH-bit fill word
- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high
- req  in  1  access request; sampled only when ready=1
- write_en  in  1  1 = write, 0 = read; qualified by req
- addr  in  ADDR_WIDTH  word address
- din  in  DATA_WIDTH  write data
- byte_en  in  NUM_BYTES  byte-lane write mask; bit i covers din[8i+7:8i]
- ready  out  1  block accepts req this cycle
- dout  out  DATA_WIDTH  read data; holds its last value until the next read completes
- dout_valid  out  1  one-cycle strobe marking new dout
- init_done  out  1  sticky high once the clear sequence has finished

## Operation
- States: CLEAR, RUN.
- Reset asserted: state=CLEAR, clear counter=0, ready=0, dout_valid=0, dout=0, init_done=0, output pipeline flushed. The array contents are not touched by reset itself.
- CLEAR with CLEAR_ON_RESET=1:
  - Each cycle writes CLEAR_VALUE (all lanes) to the counter address, then increments the counter.
  - After writing address 2**ADDR_WIDTH-1: state=RUN next cycle, init_done=1, ready=1.
  - The counter is ADDR_WIDTH+1 bits, so the terminal compare does not wrap.
- CLEAR with CLEAR_ON_RESET=0: state=RUN on the first clock after reset deasserts.
- RUN: ready=1 continuously. Accepted access = req & ready.
- Write: for each lane i with byte_en[i]=1, mem[addr] lane i <= din lane i; other lanes are unchanged.
  - byte_en=0 is a legal no-op.
  - A write never asserts dout_valid and never changes dout.
- Read: the array word at addr is captured into the data register; dout_valid pulses at the latency given under Timing.
- req while ready=0 is ignored, not queued; the requester must hold or retry.
- Reset mid-operation (during CLEAR or with a read in flight):
  - In-flight reads are dropped with no dout_valid.
  - The clear restarts from address 0.

## Timing
- Read latency, accept edge to dout_valid high: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1). dout is stable in the same cycle dout_valid is high.
- Full throughput: one access per cycle, reads and writes in any mix.
- Back-to-back reads yield back-to-back dout_valid pulses.
- Write then read of the same address on the next cycle returns the new data.
- Write latency: the array is updated at the accepting edge.
- Clear duration: exactly 2**ADDR_WIDTH cycles after reset release; ready rises on the following cycle.
- No combinational path from any input to any output. ready, dout_valid and init_done are registers.

## Structure
- Shared package ram_pkg holds:
  - the state enum {CLEAR, RUN};
  - the NUM_BYTES derivation;
  - an elaboration-time check that DATA_WIDTH%8==0 (and that OUT_REG is 0 or 1).
- Sub-module single_port_ram_be_core:
  - pure storage array with byte-lane write enables and a registered read;
  - no reset on the array, so it maps to block RAM;
  - the top level muxes between the clear sequencer and the user port onto the core.
- The top level holds the FSM, clear counter, OUT_REG stage and valid pipeline.

## Test plan
- Reset clear: ADDR_WIDTH=4, CLEAR_VALUE=32'hA5A5A5A5; release reset.
  - Required: ready=0 for 16 cycles, then ready=1 and init_done=1.
  - Reads of addresses 0..15 all return 32'hA5A5A5A5.
- Byte lanes: write 32'h11223344 with byte_en=4'hF to addr 3, then 32'hAABBCCDD with byte_en=4'b0101 to the same addr; read addr 3.
  - Required: 32'h11BB33DD with one dout_valid pulse.
- Latency and throughput, OUT_REG=0 and OUT_REG=1: issue reads of addr 0,1,2 on consecutive cycles.
  - Required: dout_valid high for 3 consecutive cycles, starting 1 and 2 cycles after the first accept respectively; data appears in issue order.
- Write-then-read: write 32'hDEADBEEF to addr 7, then read addr 7 on the next cycle.
  - Required: returns 32'hDEADBEEF.
  - dout is unchanged and dout_valid=0 during the write.
- Ignored request: assert req (write 32'h1 to addr 0) while ready=0 during CLEAR.
  - Required: addr 0 reads CLEAR_VALUE after init; no dout_valid is produced.
- Reset mid-flight: issue a read, then assert reset on the following cycle.
  - Required: no dout_valid; dout=0; ready=0; clear restarts from address 0 (init_done rises again after 2**ADDR_WIDTH cycles).
